// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state and writeback classification for the ALU
// issue path; also used by the ALU and the decode stage.
package alu_pkg;

  localparam int SP_W = 12;

  localparam logic [5:0] MUL_OP  = 6'b100001;
  localparam logic [5:0] RTN_OP  = 6'b100110;
  localparam logic [5:0] GHA_OP  = 6'b010101;
  localparam logic [5:0] GHS_OP  = 6'b010110;
  localparam logic [5:0] COMP_OP = 6'b100000;
  localparam logic [5:0] SEZ_OP  = 6'b101001;
  localparam logic [5:0] CLI_OP  = 6'b110110;
  localparam logic [5:0] BRU_OP  = 6'b110111;
  localparam logic [5:0] BRD_OP  = 6'b111000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB_LO,
    ST_WB_HI
  } state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [5:0]  op;
  } ir_t;

  // Opcodes whose low-word result must not reach the register file.
  function automatic logic no_rf_wb(input logic [5:0] opcode);
    return (opcode == GHA_OP) || (opcode == GHS_OP) || (opcode == COMP_OP) ||
           (opcode == RTN_OP) || ((opcode >= SEZ_OP) && (opcode <= CLI_OP)) ||
           (opcode == BRU_OP) || (opcode == BRD_OP);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer: captures one instruction into IR', lets the
// combinational ALU evaluate it, then sequences RF/SR/SP writeback.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter logic [5:0] MUL_OP_P = MUL_OP,
  parameter logic [5:0] RTN_OP_P = RTN_OP,
  parameter int         SP_W_P   = SP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instruction_in,
  input  logic [5:0]        opcode_in,
  input  logic              flush,
  input  logic              wb_stall,
  output logic [15:0]       alu_instruction,
  output logic [5:0]        alu_opcode,
  output logic [2:0]        rs1_addr,
  output logic [2:0]        rs2_addr,
  input  logic [15:0]       alu_out1,
  input  logic [15:0]       alu_out2,
  input  logic [7:0]        alu_status,
  input  logic [SP_W_P-1:0] alu_stack_dec,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [15:0]       rf_wdata,
  output logic              sr_we,
  output logic [7:0]        sr_wdata,
  output logic              sp_we,
  output logic [SP_W_P-1:0] sp_wdata,
  output logic              busy,
  output logic              retire
);

  state_t            state, state_nxt;
  ir_t               ir;
  logic [15:0]       res1, res2;
  logic [7:0]        res_sr;
  logic [SP_W_P-1:0] res_sp;
  logic              accept, capture;
  logic [2:0]        wb_base;

  assign alu_instruction = ir.instr;
  assign alu_opcode      = ir.op;
  assign rs1_addr        = ir.instr[10:8];
  assign rs2_addr        = ir.instr[7:5];
  assign wb_base         = ir.instr[10:8];

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign sr_wdata    = res_sr;
  assign sp_wdata    = res_sp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ir     <= '0;
      res1   <= '0;
      res2   <= '0;
      res_sr <= '0;
      res_sp <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ir <= '{instr: instruction_in, op: opcode_in};
      end
      if (capture) begin
        res1   <= alu_out1;
        res2   <= alu_out2;
        res_sr <= alu_status;
        res_sp <= alu_stack_dec;
      end
    end
  end

  // Flush beats stall; a stalled cycle holds state with every write masked so
  // each write fires exactly once when the stall releases.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    rf_we     = 1'b0;
    sr_we     = 1'b0;
    sp_we     = 1'b0;
    retire    = 1'b0;
    rf_waddr  = wb_base;
    rf_wdata  = res1;

    case (state)
      ST_IDLE: begin
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = ST_WB_LO;
        end
      end

      ST_WB_LO: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (!wb_stall) begin
          sr_we = 1'b1;
          rf_we = !no_rf_wb(ir.op);
          sp_we = (ir.op == RTN_OP_P);
          if (ir.op == MUL_OP_P) begin
            state_nxt = ST_WB_HI;
          end else begin
            retire    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_WB_HI: begin
        rf_waddr = wb_base + 3'd1;
        rf_wdata = res2;
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (!wb_stall) begin
          rf_we     = 1'b1;
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (reset) begin
      rf_we  = 1'b0;
      sr_we  = 1'b0;
      sp_we  = 1'b0;
      retire = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: stimulus pushes expected writeback
// events per cycle, a negedge monitor pops and compares them.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction_in;
  logic [5:0]  opcode_in;
  logic        flush;
  logic        wb_stall;
  logic [15:0] alu_instruction;
  logic [5:0]  alu_opcode;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [15:0] alu_out1, alu_out2;
  logic [7:0]  alu_status;
  logic [11:0] alu_stack_dec;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        sr_we;
  logic [7:0]  sr_wdata;
  logic        sp_we;
  logic [11:0] sp_wdata;
  logic        busy;
  logic        retire;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction_in(instruction_in), .opcode_in(opcode_in),
    .flush(flush), .wb_stall(wb_stall),
    .alu_instruction(alu_instruction), .alu_opcode(alu_opcode),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .alu_out1(alu_out1), .alu_out2(alu_out2),
    .alu_status(alu_status), .alu_stack_dec(alu_stack_dec),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sr_we(sr_we), .sr_wdata(sr_wdata),
    .sp_we(sp_we), .sp_wdata(sp_wdata),
    .busy(busy), .retire(retire)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } rf_ev_t;

  rf_ev_t      rfQ[$];
  logic [7:0]  srQ[$];
  logic [11:0] spQ[$];
  int          retQ[$];
  logic [1:0]  ctlQ[$];
  bit          monOn = 1'b0;
  int          testsRun = 0;
  int          testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: opcodes 21,22,32,38 and the contiguous block 41..56 skip the RF.
  function automatic bit refNoRf(input logic [5:0] opc);
    int v;
    v = int'(opc);
    return (v == 21) || (v == 22) || (v == 32) || (v == 38) || (v >= 41 && v <= 56);
  endfunction

  function automatic logic [1:0] nextCtl(input int stallPct, input int flushPct);
    logic [1:0] c;
    if (ctlQ.size() > 0) begin
      c = ctlQ.pop_front();
    end else begin
      c[1] = ($urandom_range(99) < flushPct);
      c[0] = ($urandom_range(99) < stallPct);
    end
    return c;
  endfunction

  task automatic pushPhase(input logic [15:0] ins, input logic [5:0] opc,
                           input logic [15:0] r1, input logic [15:0] r2,
                           input logic [7:0] st, input logic [11:0] sp,
                           input int p, input bit last);
    rf_ev_t e;
    if (p == 0) begin
      srQ.push_back(st);
      if (!refNoRf(opc)) begin
        e.addr = ins[10:8];
        e.data = r1;
        rfQ.push_back(e);
      end
      if (int'(opc) == 38) spQ.push_back(sp);
    end else begin
      e.addr = 3'((int'(ins[10:8]) + 1) % 8);
      e.data = r2;
      rfQ.push_back(e);
    end
    if (last) retQ.push_back(1);
  endtask

  task automatic applyStimulus(input logic [15:0] ins, input logic [5:0] opc,
                               input logic [15:0] r1, input logic [15:0] r2,
                               input logic [7:0] st, input logic [11:0] sp,
                               input int stallPct, input int flushPct);
    logic [1:0] c;
    int phases, p, guard;
    checkOutput("instr_ready idle", instr_ready, 1);
    checkOutput("busy idle", busy, 0);
    instr_valid    = 1'b1;
    instruction_in = ins;
    opcode_in      = opc;
    flush          = ($urandom_range(99) < flushPct);
    wb_stall       = ($urandom_range(99) < stallPct);
    @(posedge clk); #1;
    instr_valid    = 1'b0;
    instruction_in = 16'($urandom);
    opcode_in      = 6'($urandom);
    alu_out1       = r1;
    alu_out2       = r2;
    alu_status     = st;
    alu_stack_dec  = sp;
    checkOutput("alu_instruction", alu_instruction, ins);
    checkOutput("alu_opcode", alu_opcode, opc);
    checkOutput("rs1_addr", rs1_addr, ins[10:8]);
    checkOutput("rs2_addr", rs2_addr, ins[7:5]);
    checkOutput("busy exec", busy, 1);
    checkOutput("instr_ready exec", instr_ready, 0);
    c = nextCtl(stallPct, flushPct);
    flush    = c[1];
    wb_stall = c[0];
    @(posedge clk); #1;
    alu_out1      = 16'($urandom);
    alu_out2      = 16'($urandom);
    alu_status    = 8'($urandom);
    alu_stack_dec = 12'($urandom);
    if (c[1]) begin
      flush    = 1'b0;
      wb_stall = 1'b0;
      return;
    end
    phases = (int'(opc) == 33) ? 2 : 1;
    p      = 0;
    guard  = 0;
    while (p < phases) begin
      c = nextCtl(stallPct, flushPct);
      flush    = c[1];
      wb_stall = c[0];
      if (!c[1] && !c[0]) pushPhase(ins, opc, r1, r2, st, sp, p, p == phases - 1);
      @(posedge clk); #1;
      if (c[1]) break;
      if (!c[0]) p++;
      guard++;
      if (guard > 40) begin
        checkOutput("writeback cycle budget", guard, 0);
        break;
      end
    end
    flush    = 1'b0;
    wb_stall = 1'b0;
  endtask

  // Every expected event belongs to the current cycle, so queues must drain here.
  always @(negedge clk) begin
    rf_ev_t e;
    if (monOn && !reset) begin
      if (rfQ.size() == 0) checkOutput("rf_we unexpected", rf_we, 0);
      else begin
        e = rfQ.pop_front();
        checkOutput("rf_we", rf_we, 1);
        if (rf_we) begin
          checkOutput("rf_waddr", rf_waddr, e.addr);
          checkOutput("rf_wdata", rf_wdata, e.data);
        end
      end
      if (srQ.size() == 0) checkOutput("sr_we unexpected", sr_we, 0);
      else begin
        checkOutput("sr_we", sr_we, 1);
        checkOutput("sr_wdata", sr_wdata, srQ.pop_front());
      end
      if (spQ.size() == 0) checkOutput("sp_we unexpected", sp_we, 0);
      else begin
        checkOutput("sp_we", sp_we, 1);
        checkOutput("sp_wdata", sp_wdata, spQ.pop_front());
      end
      if (retQ.size() == 0) checkOutput("retire unexpected", retire, 0);
      else begin
        void'(retQ.pop_front());
        checkOutput("retire", retire, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] opc;
    reset = 1'b1;
    instr_valid = 1'b0; instruction_in = '0; opcode_in = '0;
    flush = 1'b0; wb_stall = 1'b0;
    alu_out1 = '0; alu_out2 = '0; alu_status = '0; alu_stack_dec = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset instr_ready", instr_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rf_we", rf_we, 0);
    checkOutput("reset sr_we", sr_we, 0);
    checkOutput("reset sp_we", sp_we, 0);
    checkOutput("reset retire", retire, 0);
    checkOutput("reset alu_instruction", alu_instruction, 0);
    checkOutput("reset alu_opcode", alu_opcode, 0);
    reset = 1'b0;
    monOn = 1'b1;
    @(posedge clk); #1;

    // ADD R2+R5 -> R2
    applyStimulus(16'h02A0, 6'b010001, 16'h0007, 16'h0000, 8'h5A, 12'h000, 0, 0);
    // MUL R7*R1: low word to R7, high word wraps to R0
    applyStimulus(16'h0720, 6'b100001, 16'h3400, 16'h0012, 8'h11, 12'h000, 0, 0);
    // GHS: status only
    applyStimulus(16'h0360, 6'b010110, 16'hBEEF, 16'h0000, 8'hC3, 12'h000, 0, 0);
    // RTN: stack write, no RF write
    applyStimulus(16'h0100, 6'b100110, 16'h1111, 16'h0000, 8'h22, 12'h0FE, 0, 0);

    // MUL: EXEC clean, two stalls in WB_LO, low write, flush in WB_HI
    ctlQ = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    applyStimulus(16'h0520, 6'b100001, 16'hA5A5, 16'h5A5A, 8'h33, 12'h000, 0, 0);

    // Reset in WB_HI with a concurrent instr_valid that must be dropped
    instr_valid = 1'b1; instruction_in = 16'h0640; opcode_in = 6'b100001;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    alu_out1 = 16'h1357; alu_out2 = 16'h2468; alu_status = 8'h44; alu_stack_dec = 12'h0;
    @(posedge clk); #1;
    pushPhase(16'h0640, 6'b100001, 16'h1357, 16'h2468, 8'h44, 12'h0, 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    instr_valid = 1'b1; instruction_in = 16'hFFFF; opcode_in = 6'b010001;
    @(posedge clk); #1;
    reset = 1'b0;
    instr_valid = 1'b0;
    checkOutput("post-reset busy", busy, 0);
    checkOutput("post-reset instr_ready", instr_ready, 1);
    checkOutput("post-reset rf_we", rf_we, 0);
    checkOutput("post-reset sr_we", sr_we, 0);
    checkOutput("post-reset alu_instruction", alu_instruction, 0);
    @(posedge clk); #1;
    checkOutput("reset-cycle valid not captured", busy, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0:       opc = 6'b100001;
        1:       opc = 6'b100110;
        default: opc = 6'($urandom);
      endcase
      applyStimulus(16'($urandom), opc, 16'($urandom), 16'($urandom),
                    8'($urandom), 12'($urandom), 25, 8);
    end

    repeat (3) @(posedge clk);
    #1;
    monOn = 1'b0;
    checkOutput("rf queue drained", rfQ.size(), 0);
    checkOutput("sr queue drained", srQ.size(), 0);
    checkOutput("sp queue drained", spQ.size(), 0);
    checkOutput("retire queue drained", retQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle sequencer between the instruction register and the combinational ALU.
- Accepts one decoded instruction at a time over a valid/ready handshake and captures it into an internal IR'.
- Presents IR' to the ALU and samples the ALU results.
- Sequences register-file, status-register and stack-register writeback. MUL takes two writeback cycles: low word, then high word.
- Sits between the decode stage and the register file / status register of the CPU.

Parameters:
MUL_OP, 6'b100001, encoded opcode whose 32-bit product is written back over two cycles.
RTN_OP, 6'b100110, encoded opcode that writes the decremented stack register.
SP_W, 12, stack register width.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
instr_valid  in  1  decode presents an instruction
instr_ready  out  1  controller can accept an instruction (IDLE only)
instruction_in  in  16  raw instruction word
opcode_in  in  6  encoded opcode
flush  in  1  abort the in-flight instruction
wb_stall  in  1  hold the current writeback cycle
alu_instruction  out  16  IR' instruction to the ALU
alu_opcode  out  6  IR' opcode to the ALU
rs1_addr  out  3  register-file read port 1, = IR'[10:8]
rs2_addr  out  3  register-file read port 2, = IR'[7:5]
alu_out1  in  16  ALU result low word
alu_out2  in  16  ALU result high word (MUL)
alu_status  in  8  ALU status output
alu_stack_dec  in  SP_W  ALU decremented stack value
rf_we  out  1  register-file write enable
rf_waddr  out  3  write address
rf_wdata  out  16  write data
sr_we  out  1  status-register write enable
sr_wdata  out  8  status write data
sp_we  out  1  stack-register write enable
sp_wdata  out  SP_W  stack write data
busy  out  1  high in any state other than IDLE
retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset values: state=IDLE, IR'=0, all result registers 0, every *_we=0, retire=0, busy=0, instr_ready=1. Reset overrides every other input in any state.
- States: IDLE, EXEC, WB_LO, WB_HI.
- IDLE:
  - instr_ready=1.
  - On instr_valid: IR' <= {instruction_in, opcode_in}, go to EXEC.
  - No other input has any effect.
- EXEC (1 cycle):
  - alu_* and rs*_addr are driven from IR'. The ALU is combinational.
  - At the clock edge, capture res1=alu_out1, res2=alu_out2, res_sr=alu_status, res_sp=alu_stack_dec. Go to WB_LO.
- WB_LO:
  - sr_we=1 with sr_wdata=res_sr, for every opcode.
  - rf_we=1 with rf_waddr=IR'[10:8] and rf_wdata=res1, unless the opcode is no-writeback: 010101, 010110, 100000, 100110, 101001–110110, 110111, 111000.
  - sp_we=1 with sp_wdata=res_sp only when opcode==RTN_OP.
  - Next state is WB_HI if opcode==MUL_OP, otherwise IDLE with retire=1 in this cycle.
- WB_HI:
  - rf_we=1, rf_waddr=IR'[10:8]+1 (3-bit wrap, so 7→0), rf_wdata=res2, sr_we=0.
  - retire=1, then go to IDLE.
- wb_stall=1 in WB_LO or WB_HI:
  - All write enables and retire are forced 0 and the state holds.
  - Outputs resume unchanged once stall drops.
  - Each write is performed exactly once.
- wb_stall in IDLE or EXEC is ignored.
- flush=1 in EXEC, WB_LO or WB_HI:
  - Writes and retire are suppressed that cycle and the next state is IDLE.
  - A WB_LO already completed before WB_HI is not undone.
- flush in IDLE is ignored.
- Simultaneous flush and wb_stall: flush wins.
- Latency:
  - Accept to retire is 2 cycles, or 3 for MUL.
  - Back-to-back throughput is one instruction per 3 cycles (4 for MUL), because instr_ready is low outside IDLE.

Decomposition:
Shared package alu_pkg holds:
- the opcode constants: MUL_OP, RTN_OP, GHA=010101, GHS=010110, COMP=100000, SEZ..CLI range bounds, BRU, BRD;
- the state enum;
- a function no_rf_wb(opcode).

The same constants are used by the ALU and decode. No sub-module; a single FSM plus result registers.

Test Plan:
- ADD (010001), rs1=R2=0x0003, rs2=R5=0x0004 → WB_LO: rf_we, rf_waddr=2, rf_wdata=0x0007, sr_we; retire 2 cycles after accept.
- MUL_OP, R7=0x1234, R1=0x0100 → WB_LO writes R7=0x3400; WB_HI writes R0=0x0012 (address wrap); retire on the third cycle.
- GHS (010110) → rf_we stays 0 throughout; sr_we=1 in WB_LO with sr_wdata equal to the ALU status input.
- RTN_OP, alu_stack_dec=0x0FE → sp_we=1, sp_wdata=0x0FE; rf_we=0.
- MUL with wb_stall held 2 cycles in WB_LO, then flush asserted in WB_HI → low word written exactly once; high word never written; no retire; back in IDLE with instr_ready=1.
- reset asserted in WB_HI → next cycle: IDLE, all write enables 0, instr_ready=1; instr_valid in that reset cycle is not captured.
